// File: rtl/instr_sequencer_pkg.sv
// Shared encodings and state type for the per-column instruction sequencer.
// The NOP and ECALL words are the RISC-V encodings the data path expects.
package instr_sequencer_pkg;

    localparam int DWIDTH_INST = 32;

    localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;
    localparam logic [31:0] ECALL_INSTR = 32'h0000_0073;

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_READY,
        ST_RUN,
        ST_DONE
    } seq_state_t;

endpackage

// File: rtl/instr_sequencer_imem.sv
// One column's instruction memory: one write port, one registered read port.
// Contents are never cleared, so a loaded program survives reset.
module instr_mem #(
    parameter int dwidth = 32,
    parameter int depth  = 256,
    parameter int aw     = $clog2(depth)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [aw-1:0]     wr_addr,
    input  logic [dwidth-1:0] wr_data,
    input  logic [aw-1:0]     rd_addr,
    output logic [dwidth-1:0] rd_data
);

    logic [dwidth-1:0] mem [depth];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/instr_sequencer.sv
// Loads per-column instruction memories from a host stream, then fetches one
// instruction per column for the CGRA, each column halting on ecall or PC error.
module instr_sequencer
    import instr_sequencer_pkg::*;
#(
    parameter int dwidth_inst = DWIDTH_INST,
    parameter int num_col     = 4,
    parameter int imem_depth  = 256,
    parameter int imem_aw     = $clog2(imem_depth)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           load_tvalid,
    output logic                           load_tready,
    input  logic [dwidth_inst-1:0]         load_tdata,
    input  logic [$clog2(num_col)-1:0]     load_col,
    input  logic [imem_aw-1:0]             load_addr,
    input  logic                           load_tlast,
    output logic                           done_loader,
    input  logic                           start,
    output logic [dwidth_inst*num_col-1:0] instr,
    output logic [num_col-1:0]             instr_valid,
    input  logic [num_col-1:0]             advance,
    input  logic                           t_stall,
    input  logic [num_col-1:0]             branch_taken,
    input  logic [12*num_col-1:0]          branch_offset,
    output logic [num_col-1:0]             halted,
    output logic                           all_done,
    output logic [num_col-1:0]             pc_err
);

    localparam int cw = $clog2(num_col);
    // Wide enough that PC plus the largest word offset never wraps before the range check.
    localparam int sw = imem_aw + 12;
    localparam logic signed [sw-1:0]        pc_max = sw'(imem_depth - 1);
    localparam logic [dwidth_inst-1:0]      nop_w   = dwidth_inst'(NOP_INSTR);
    localparam logic [dwidth_inst-1:0]      ecall_w = dwidth_inst'(ECALL_INSTR);

    seq_state_t state;
    logic       run_start;

    assign run_start = start && ((state == ST_READY) || (state == ST_DONE));

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_LOAD;
            load_tready <= 1'b1;
            done_loader <= 1'b0;
            all_done    <= 1'b0;
        end else begin
            case (state)
                ST_LOAD: begin
                    if (load_tvalid && load_tlast) begin
                        state       <= ST_READY;
                        load_tready <= 1'b0;
                        done_loader <= 1'b1;
                    end
                end
                ST_READY: begin
                    if (start) begin
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (&halted) begin
                        state    <= ST_DONE;
                        all_done <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (start) begin
                        state    <= ST_RUN;
                        all_done <= 1'b0;
                    end
                end
                default: state <= ST_LOAD;
            endcase
        end
    end

    for (genvar j = 0; j < num_col; j++) begin : g_col
        logic [imem_aw-1:0]     pc;
        logic                   valid_q;
        logic                   halt_q;
        logic                   err_q;
        logic [dwidth_inst-1:0] rd_data;
        logic [11:0]            boff;
        logic signed [sw-1:0]   off_ext;
        logic signed [sw-1:0]   off_words;
        logic signed [sw-1:0]   pc_ext;
        logic signed [sw-1:0]   next_pc;
        logic                   bad_target;

        instr_mem #(
            .dwidth (dwidth_inst),
            .depth  (imem_depth),
            .aw     (imem_aw)
        ) u_mem (
            .clk     (clk),
            .wr_en   ((state == ST_LOAD) && load_tvalid && (load_col == cw'(j))),
            .wr_addr (load_addr),
            .wr_data (load_tdata),
            .rd_addr (pc),
            .rd_data (rd_data)
        );

        assign boff = branch_offset[j*12 +: 12];

        always_comb begin
            off_ext    = {{(sw-12){boff[11]}}, boff};
            off_words  = off_ext >>> 2;
            pc_ext     = {{(sw-imem_aw){1'b0}}, pc};
            next_pc    = branch_taken[j] ? (pc_ext + off_words) : (pc_ext + sw'(1));
            bad_target = (branch_taken[j] && (boff[1:0] != 2'b00))
                         || next_pc[sw-1] || (next_pc > pc_max);
        end

        // A fresh PC always costs one bubble cycle while the registered read catches up.
        always_ff @(posedge clk) begin
            if (rst || run_start) begin
                pc      <= '0;
                valid_q <= 1'b0;
                halt_q  <= 1'b0;
                err_q   <= 1'b0;
            end else if ((state == ST_RUN) && !t_stall && !halt_q) begin
                if (!valid_q) begin
                    valid_q <= 1'b1;
                end else if (rd_data == ecall_w) begin
                    valid_q <= 1'b0;
                    halt_q  <= 1'b1;
                end else if (advance[j]) begin
                    valid_q <= 1'b0;
                    if (bad_target) begin
                        halt_q <= 1'b1;
                        err_q  <= 1'b1;
                    end else begin
                        pc <= next_pc[imem_aw-1:0];
                    end
                end
            end
        end

        assign instr[j*dwidth_inst +: dwidth_inst] = valid_q ? rd_data : nop_w;
        assign instr_valid[j] = valid_q;
        assign halted[j]      = halt_q;
        assign pc_err[j]      = err_q;
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a reference model.
module tb_instr_sequencer;

    localparam int NCOL  = 4;
    localparam int DEPTH = 8;
    localparam int AW    = 3;
    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam logic [31:0] ECALL = 32'h0000_0073;
    localparam logic [31:0] ADDI1 = 32'h0010_0093;
    localparam logic [31:0] ADDI2 = 32'h0020_0113;
    localparam int PH_LOAD = 0, PH_READY = 1, PH_RUN = 2, PH_DONE = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          load_tvalid = 1'b0;
    logic          load_tready;
    logic [31:0]   load_tdata = '0;
    logic [1:0]    load_col = '0;
    logic [AW-1:0] load_addr = '0;
    logic          load_tlast = 1'b0;
    logic          done_loader;
    logic          start = 1'b0;
    logic [127:0]  instr;
    logic [3:0]    instr_valid;
    logic [3:0]    advance = '0;
    logic          t_stall = 1'b0;
    logic [3:0]    branch_taken = '0;
    logic [47:0]   branch_offset = '0;
    logic [3:0]    halted;
    logic          all_done;
    logic [3:0]    pc_err;

    instr_sequencer #(
        .dwidth_inst (32),
        .num_col     (NCOL),
        .imem_depth  (DEPTH),
        .imem_aw     (AW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .load_tvalid   (load_tvalid),
        .load_tready   (load_tready),
        .load_tdata    (load_tdata),
        .load_col      (load_col),
        .load_addr     (load_addr),
        .load_tlast    (load_tlast),
        .done_loader   (done_loader),
        .start         (start),
        .instr         (instr),
        .instr_valid   (instr_valid),
        .advance       (advance),
        .t_stall       (t_stall),
        .branch_taken  (branch_taken),
        .branch_offset (branch_offset),
        .halted        (halted),
        .all_done      (all_done),
        .pc_err        (pc_err)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail = 0;
    bit          chk_en = 1'b0;
    logic [31:0] img [NCOL][DEPTH];

    // Reference model: phase, per-column PC/valid/halt/error, and its own copy of the memories.
    int          m_phase = PH_LOAD;
    bit          m_done_loader = 1'b0;
    bit          m_all_done = 1'b0;
    int          m_pc [NCOL];
    bit          m_valid [NCOL];
    bit          m_halt [NCOL];
    bit          m_err [NCOL];
    logic [31:0] m_prog [NCOL][DEPTH];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic void clearColumns();
        for (int j = 0; j < NCOL; j++) begin
            m_pc[j]    = 0;
            m_valid[j] = 1'b0;
            m_halt[j]  = 1'b0;
            m_err[j]   = 1'b0;
        end
    endfunction

    // One cycle of a running column, stated as fetch / halt / retire rules on integer PCs.
    function automatic void stepColumn(input int j);
        int off;
        int tgt;
        bit bad;
        if (t_stall || m_halt[j]) return;
        if (!m_valid[j]) begin
            m_valid[j] = 1'b1;
            return;
        end
        if (m_prog[j][m_pc[j]] == ECALL) begin
            m_valid[j] = 1'b0;
            m_halt[j]  = 1'b1;
            return;
        end
        if (!advance[j]) return;
        m_valid[j] = 1'b0;
        off = int'($signed(branch_offset[j*12 +: 12]));
        bad = 1'b0;
        if (branch_taken[j]) begin
            bad = (off % 4) != 0;
            tgt = m_pc[j] + off / 4;
        end else begin
            tgt = m_pc[j] + 1;
        end
        if (bad || tgt < 0 || tgt >= DEPTH) begin
            m_halt[j] = 1'b1;
            m_err[j]  = 1'b1;
        end else begin
            m_pc[j] = tgt;
        end
    endfunction

    always @(posedge clk) begin
        bit all_h;
        if (rst) begin
            m_phase       = PH_LOAD;
            m_done_loader = 1'b0;
            m_all_done    = 1'b0;
            clearColumns();
        end else if (m_phase == PH_LOAD) begin
            if (load_tvalid) begin
                m_prog[load_col][load_addr] = load_tdata;
                if (load_tlast) begin
                    m_phase       = PH_READY;
                    m_done_loader = 1'b1;
                end
            end
        end else if (m_phase == PH_READY || m_phase == PH_DONE) begin
            if (start) begin
                m_phase    = PH_RUN;
                m_all_done = 1'b0;
                clearColumns();
            end
        end else begin
            all_h = 1'b1;
            for (int j = 0; j < NCOL; j++) all_h = all_h & m_halt[j];
            for (int j = 0; j < NCOL; j++) stepColumn(j);
            if (all_h) begin
                m_phase    = PH_DONE;
                m_all_done = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            checkOutput("load_tready", 32'(load_tready), 32'(m_phase == PH_LOAD));
            checkOutput("done_loader", 32'(done_loader), 32'(m_done_loader));
            checkOutput("all_done", 32'(all_done), 32'(m_all_done));
            for (int j = 0; j < NCOL; j++) begin
                checkOutput($sformatf("instr_valid[%0d]", j), 32'(instr_valid[j]), 32'(m_valid[j]));
                checkOutput($sformatf("halted[%0d]", j), 32'(halted[j]), 32'(m_halt[j]));
                checkOutput($sformatf("pc_err[%0d]", j), 32'(pc_err[j]), 32'(m_err[j]));
                checkOutput($sformatf("instr[%0d]", j), instr[j*32 +: 32],
                            m_valid[j] ? m_prog[j][m_pc[j]] : NOP);
            end
        end
    end

    task automatic resetDut();
        rst = 1'b1;
        applyStimulus(2);
        rst = 1'b0;
    endtask

    task automatic loadImage(input bit noisy);
        for (int c = 0; c < NCOL; c++) begin
            for (int a = 0; a < DEPTH; a++) begin
                while (noisy && $urandom_range(0, 3) == 0) begin
                    load_tvalid = 1'b0;
                    start = ($urandom_range(0, 1) == 0);
                    applyStimulus(1);
                end
                load_tvalid = 1'b1;
                load_col    = 2'(c);
                load_addr   = AW'(a);
                load_tdata  = img[c][a];
                load_tlast  = (c == NCOL - 1) && (a == DEPTH - 1);
                start       = noisy && ($urandom_range(0, 3) == 0);
                applyStimulus(1);
            end
        end
        load_tvalid = 1'b0;
        load_tlast  = 1'b0;
        start       = 1'b0;
    endtask

    task automatic waitAllDone(input int budget, input string name);
        int k = 0;
        while (!all_done && k < budget) begin
            applyStimulus(1);
            k++;
        end
        checkOutput(name, 32'(all_done), 32'd1);
    endtask

    task automatic fillSimpleImage();
        for (int c = 0; c < NCOL; c++)
            for (int a = 0; a < DEPTH; a++)
                img[c][a] = (a == 0) ? ECALL : NOP;
    endtask

    initial begin
        logic [31:0] seq_b [7];
        int off;

        applyStimulus(1);
        chk_en = 1'b1;
        applyStimulus(1);
        checkOutput("rst_load_tready", 32'(load_tready), 32'd1);
        checkOutput("rst_done_loader", 32'(done_loader), 32'd0);
        checkOutput("rst_instr_valid", 32'(instr_valid), 32'd0);
        checkOutput("rst_instr0", instr[31:0], NOP);
        checkOutput("rst_instr3", instr[127:96], NOP);
        rst = 1'b0;

        $display("[TB] short load with start pulsed mid-stream");
        for (int a = 0; a < 4; a++) begin
            load_tvalid = 1'b1;
            load_col    = 2'd0;
            load_addr   = AW'(a);
            load_tdata  = 32'hA000_0000 + 32'(a);
            load_tlast  = (a == 3);
            start       = (a == 1);
            if (a == 3) checkOutput("done_loader_on_tlast_beat", 32'(done_loader), 32'd0);
            applyStimulus(1);
        end
        load_tvalid = 1'b0;
        load_tlast  = 1'b0;
        start       = 1'b0;
        checkOutput("done_loader_after_tlast", 32'(done_loader), 32'd1);
        checkOutput("load_tready_after_tlast", 32'(load_tready), 32'd0);
        applyStimulus(3);
        checkOutput("start_in_load_ignored", 32'(instr_valid), 32'd0);

        $display("[TB] addi/addi/ecall on column 0");
        fillSimpleImage();
        img[0][0] = ADDI1;
        img[0][1] = ADDI2;
        img[0][2] = ECALL;
        resetDut();
        loadImage(1'b0);
        advance = 4'b0001;
        start = 1'b1;
        applyStimulus(1);
        start = 1'b0;
        seq_b = '{NOP, ADDI1, NOP, ADDI2, NOP, ECALL, NOP};
        for (int k = 0; k < 7; k++) begin
            checkOutput($sformatf("col0_seq_%0d", k), instr[31:0], seq_b[k]);
            applyStimulus(1);
        end
        checkOutput("col0_halted", 32'(halted[0]), 32'd1);
        checkOutput("all_done_after_ecalls", 32'(all_done), 32'd1);

        $display("[TB] branch back on column 1, overflow on columns 1 and 2");
        fillSimpleImage();
        for (int a = 0; a < DEPTH; a++) begin
            img[1][a] = 32'hC100_0000 + 32'(a);
            img[2][a] = 32'hC200_0000 + 32'(a);
        end
        resetDut();
        loadImage(1'b0);
        advance = 4'b1111;
        start = 1'b1;
        applyStimulus(1);
        start = 1'b0;
        applyStimulus(11);
        checkOutput("col1_at_pc5", instr[63:32], 32'hC100_0005);
        branch_taken = 4'b0010;
        branch_offset[23:12] = 12'hFF8;
        applyStimulus(1);
        branch_taken = 4'b0000;
        branch_offset = '0;
        checkOutput("col1_bubble_after_branch", 32'(instr_valid[1]), 32'd0);
        applyStimulus(1);
        checkOutput("col1_branch_target_pc3", instr[63:32], 32'hC100_0003);
        applyStimulus(9);
        checkOutput("col1_overflow_err", 32'(pc_err[1]), 32'd1);
        checkOutput("col1_overflow_halt", 32'(halted[1]), 32'd1);
        checkOutput("col1_overflow_nop", instr[63:32], NOP);
        checkOutput("col2_overflow_err", 32'(pc_err[2]), 32'd1);
        applyStimulus(1);
        checkOutput("all_done_after_overflow", 32'(all_done), 32'd1);

        $display("[TB] rerun from DONE with a 10-cycle stall");
        start = 1'b1;
        applyStimulus(1);
        start = 1'b0;
        applyStimulus(3);
        t_stall = 1'b1;
        for (int k = 0; k < 10; k++) begin
            checkOutput($sformatf("stall_hold_%0d", k), instr[95:64], 32'hC200_0001);
            applyStimulus(1);
        end
        t_stall = 1'b0;
        checkOutput("stall_release_same", instr[95:64], 32'hC200_0001);
        applyStimulus(1);
        checkOutput("stall_release_bubble", 32'(instr_valid[2]), 32'd0);
        applyStimulus(1);
        checkOutput("stall_release_next", instr[95:64], 32'hC200_0002);
        waitAllDone(60, "all_done_after_stall_run");

        $display("[TB] reset during RUN, reload and restart");
        advance = 4'b0000;
        start = 1'b1;
        applyStimulus(1);
        start = 1'b0;
        applyStimulus(4);
        rst = 1'b1;
        applyStimulus(1);
        checkOutput("midrun_rst_tready", 32'(load_tready), 32'd1);
        checkOutput("midrun_rst_done_loader", 32'(done_loader), 32'd0);
        checkOutput("midrun_rst_valid", 32'(instr_valid), 32'd0);
        checkOutput("midrun_rst_halted", 32'(halted), 32'd0);
        checkOutput("midrun_rst_instr2", instr[95:64], NOP);
        rst = 1'b0;
        loadImage(1'b0);
        start = 1'b1;
        applyStimulus(1);
        start = 1'b0;
        applyStimulus(1);
        checkOutput("restart_col2_pc0", instr[95:64], 32'hC200_0000);
        checkOutput("restart_col2_valid", 32'(instr_valid[2]), 32'd1);

        $display("[TB] randomized programs and control traffic");
        for (int round = 0; round < 3; round++) begin
            for (int c = 0; c < NCOL; c++)
                for (int a = 0; a < DEPTH; a++)
                    img[c][a] = ($urandom_range(0, 4) == 0) ? ECALL : $urandom;
            resetDut();
            loadImage(1'b1);
            for (int cyc = 0; cyc < 300; cyc++) begin
                advance      = 4'($urandom);
                branch_taken = 4'($urandom & $urandom);
                for (int j = 0; j < NCOL; j++) begin
                    off = ($urandom_range(0, 8) - 4) * 4;
                    if ($urandom_range(0, 7) == 0) off = off + $urandom_range(1, 3);
                    branch_offset[j*12 +: 12] = 12'(off);
                end
                t_stall = ($urandom_range(0, 5) == 0);
                start   = ($urandom_range(0, 15) == 0);
                applyStimulus(1);
            end
            advance = '0;
            branch_taken = '0;
            branch_offset = '0;
            t_stall = 1'b0;
            start = 1'b0;
        end

        applyStimulus(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        n_fail++;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
